// File: rtl/car_kinematics_pkg.sv
// car_kinematics_pkg: shared widths, motion constants and pose/control types for the car integrator.
package car_kinematics_pkg;
    localparam int ANG_WIDTH   = 9;
    localparam int MAP_H_WIDTH = 11;
    localparam int MAP_V_WIDTH = 11;
    localparam int FRAC_BITS   = 4;
    localparam int SPD_W       = 10;
    localparam int TRIG_W      = 10;
    localparam int MAX_SPEED   = 256;
    localparam int ACCEL       = 8;
    localparam int BRAKE       = 24;
    localparam int DRAG        = 2;
    localparam int TURN_STEP   = 3;
    localparam int X_MIN       = -800;
    localparam int X_MAX       = 800;
    localparam int Y_MIN       = -600;
    localparam int Y_MAX       = 600;
    localparam int RST_X       = 0;
    localparam int RST_Y       = 0;
    localparam int RST_ANG     = 0;

    typedef enum logic [2:0] {IDLE, STEER, LOOKUP, MUL, MOVE, DONE} state_t;

    typedef struct packed {
        logic signed [MAP_H_WIDTH-1:0] x;
        logic signed [MAP_V_WIDTH-1:0] y;
        logic [ANG_WIDTH-1:0]          angle;
    } car_pose_t;

    typedef struct packed {
        logic left;
        logic right;
        logic throttle;
        logic brake;
    } car_ctrl_t;
endpackage

// File: rtl/car_trig_lut.sv
// car_trig_lut: sin/cos of 0..359 degrees in signed Q1.8 from a folded 0..90 quarter-wave table.
module car_trig_lut
    import car_kinematics_pkg::*;
(
    input  logic [ANG_WIDTH-1:0]     angle,
    output logic signed [TRIG_W-1:0] sin_q,
    output logic signed [TRIG_W-1:0] cos_q
);
    localparam logic [ANG_WIDTH-1:0] A90  = ANG_WIDTH'(90);
    localparam logic [ANG_WIDTH-1:0] A180 = ANG_WIDTH'(180);
    localparam logic [ANG_WIDTH-1:0] A270 = ANG_WIDTH'(270);
    localparam logic [ANG_WIDTH-1:0] A360 = ANG_WIDTH'(360);
    // round(256 * sin(d)) for d = 0..90
    localparam logic [8:0] SIN_TAB [91] = '{
          0,   4,   9,  13,  18,  22,  27,  31,  36,  40,
         44,  49,  53,  58,  62,  66,  71,  75,  79,  83,
         88,  92,  96, 100, 104, 108, 112, 116, 120, 124,
        128, 132, 136, 139, 143, 147, 150, 154, 158, 161,
        165, 168, 171, 175, 178, 181, 184, 187, 190, 193,
        196, 199, 202, 204, 207, 210, 212, 215, 217, 219,
        222, 224, 226, 228, 230, 232, 234, 236, 237, 239,
        241, 242, 243, 245, 246, 247, 248, 249, 250, 251,
        252, 253, 254, 254, 255, 255, 255, 256, 256, 256,
        256
    };

    logic [6:0] s_a, c_a;
    logic [8:0] s_m, c_m;

    always_comb begin
        s_a   = 7'((angle <= A90)  ? angle
              :    (angle <= A180) ? A180 - angle
              :    (angle <= A270) ? angle - A180
              :                      A360 - angle);
        c_a   = 7'((angle <= A90)  ? A90 - angle
              :    (angle <= A180) ? angle - A90
              :    (angle <= A270) ? A270 - angle
              :                      angle - A270);
        s_m   = SIN_TAB[s_a];
        c_m   = SIN_TAB[c_a];
        sin_q = (angle > A180) ? -$signed({1'b0, s_m}) : $signed({1'b0, s_m});
        cos_q = (angle > A90 && angle < A270) ? -$signed({1'b0, c_m}) : $signed({1'b0, c_m});
    end
endmodule

// File: rtl/car_kinematics.sv
// car_kinematics: per-car frame integrator for steering, speed and clamped fixed-point position.
// One update walks IDLE->STEER->LOOKUP->MUL->MOVE->DONE; load aborts it and re-seeds the pose.
module car_kinematics
    import car_kinematics_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_tick,
    input  logic                          load,
    input  logic signed [MAP_H_WIDTH-1:0] init_x,
    input  logic signed [MAP_V_WIDTH-1:0] init_y,
    input  logic [ANG_WIDTH-1:0]          init_angle,
    input  logic                          steer_left,
    input  logic                          steer_right,
    input  logic                          throttle,
    input  logic                          brake,
    output logic signed [MAP_H_WIDTH-1:0] x,
    output logic signed [MAP_V_WIDTH-1:0] y,
    output logic [ANG_WIDTH-1:0]          angle,
    output logic [SPD_W-1:0]              speed,
    output logic                          valid,
    output logic                          busy,
    output logic                          wall_hit,
    output logic                          tick_drop
);
    // accumulators carry one guard bit above the map width so a step past the edge is still visible
    localparam int IX_W = MAP_H_WIDTH + 1;
    localparam int IY_W = MAP_V_WIDTH + 1;
    localparam int AX_W = IX_W + FRAC_BITS;
    localparam int AY_W = IY_W + FRAC_BITS;
    localparam int PW   = SPD_W + TRIG_W + 1;
    localparam logic signed [IX_W-1:0] XLO = IX_W'(X_MIN);
    localparam logic signed [IX_W-1:0] XHI = IX_W'(X_MAX);
    localparam logic signed [IY_W-1:0] YLO = IY_W'(Y_MIN);
    localparam logic signed [IY_W-1:0] YHI = IY_W'(Y_MAX);
    localparam logic [ANG_WIDTH-1:0] A360  = ANG_WIDTH'(360);
    localparam logic [ANG_WIDTH-1:0] ATURN = ANG_WIDTH'(TURN_STEP);
    localparam logic [SPD_W-1:0] S_MAX   = SPD_W'(MAX_SPEED);
    localparam logic [SPD_W-1:0] S_ACC   = SPD_W'(ACCEL);
    localparam logic [SPD_W-1:0] S_BRAKE = SPD_W'(BRAKE);
    localparam logic [SPD_W-1:0] S_DRAG  = SPD_W'(DRAG);

    state_t                   state, nxt;
    car_ctrl_t                ctrl;
    car_pose_t                pose;
    logic [ANG_WIDTH-1:0]     ang, ang_nxt, ang_load;
    logic [SPD_W-1:0]         spd, spd_nxt;
    logic signed [AX_W-1:0]   pos_x, dx;
    logic signed [AY_W-1:0]   pos_y, dy;
    logic signed [TRIG_W-1:0] sin_v, cos_v, sin_r, cos_r;
    logic signed [PW-1:0]     prod_x, prod_y;
    logic signed [IX_W-1:0]   ix, cx;
    logic signed [IY_W-1:0]   iy, cy;
    logic                     hit_x, hit_y;

    car_trig_lut u_trig (
        .angle (ang),
        .sin_q (sin_v),
        .cos_q (cos_v)
    );

    assign x     = pose.x;
    assign y     = pose.y;
    assign angle = pose.angle;
    assign speed = spd;

    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = frame_tick ? STEER : IDLE;
            STEER:   nxt = LOOKUP;
            LOOKUP:  nxt = MUL;
            MUL:     nxt = MOVE;
            MOVE:    nxt = DONE;
            default: nxt = IDLE;
        endcase
        if (load) nxt = IDLE;
    end

    always_comb busy = (state != IDLE);

    always_comb begin
        ang_nxt  = (ctrl.left && !ctrl.right) ? ((ang >= A360 - ATURN) ? ang + ATURN - A360 : ang + ATURN)
                 : (ctrl.right && !ctrl.left) ? ((ang < ATURN) ? ang + A360 - ATURN : ang - ATURN)
                 : ang;
        spd_nxt  = ctrl.brake    ? ((spd > S_BRAKE) ? spd - S_BRAKE : '0)
                 : ctrl.throttle ? ((spd >= S_MAX - S_ACC) ? S_MAX : spd + S_ACC)
                 :                 ((spd > S_DRAG) ? spd - S_DRAG : '0);
        ang_load = (init_angle >= A360) ? init_angle - A360 : init_angle;
        prod_x   = PW'($signed({1'b0, spd})) * PW'(cos_r);
        prod_y   = PW'($signed({1'b0, spd})) * PW'(sin_r);
        ix       = pos_x[AX_W-1:FRAC_BITS];
        iy       = pos_y[AY_W-1:FRAC_BITS];
        cx       = (ix < XLO) ? XLO : (ix > XHI) ? XHI : ix;
        cy       = (iy < YLO) ? YLO : (iy > YHI) ? YHI : iy;
        hit_x    = (cx != ix);
        hit_y    = (cy != iy);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl      <= '0;
            ang       <= ANG_WIDTH'(RST_ANG);
            spd       <= '0;
            pos_x     <= AX_W'(RST_X * (2 ** FRAC_BITS));
            pos_y     <= AY_W'(RST_Y * (2 ** FRAC_BITS));
            sin_r     <= '0;
            cos_r     <= '0;
            dx        <= '0;
            dy        <= '0;
            pose      <= '{x: MAP_H_WIDTH'(RST_X), y: MAP_V_WIDTH'(RST_Y), angle: ANG_WIDTH'(RST_ANG)};
            valid     <= 1'b0;
            wall_hit  <= 1'b0;
            tick_drop <= 1'b0;
        end else begin
            valid     <= 1'b0;
            wall_hit  <= 1'b0;
            tick_drop <= frame_tick && busy && !load;
            if (load) begin
                ang   <= ang_load;
                spd   <= '0;
                pos_x <= {init_x[MAP_H_WIDTH-1], init_x, {FRAC_BITS{1'b0}}};
                pos_y <= {init_y[MAP_V_WIDTH-1], init_y, {FRAC_BITS{1'b0}}};
                pose  <= '{x: init_x, y: init_y, angle: ang_load};
            end else begin
                case (state)
                    IDLE:   ctrl <= frame_tick ? car_ctrl_t'({steer_left, steer_right, throttle, brake}) : ctrl;
                    STEER: begin
                        ang <= ang_nxt;
                        spd <= spd_nxt;
                    end
                    LOOKUP: begin
                        sin_r <= sin_v;
                        cos_r <= cos_v;
                    end
                    MUL: begin
                        dx <= AX_W'(prod_x >>> 8);
                        dy <= AY_W'(prod_y >>> 8);
                    end
                    MOVE: begin
                        pos_x <= pos_x + dx;
                        pos_y <= pos_y + dy;
                    end
                    DONE: begin
                        pos_x    <= hit_x ? {cx, {FRAC_BITS{1'b0}}} : pos_x;
                        pos_y    <= hit_y ? {cy, {FRAC_BITS{1'b0}}} : pos_y;
                        spd      <= (hit_x || hit_y) ? '0 : spd;
                        pose     <= '{x: cx[MAP_H_WIDTH-1:0], y: cy[MAP_V_WIDTH-1:0], angle: ang};
                        valid    <= 1'b1;
                        wall_hit <= hit_x || hit_y;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
